// File: rtl/fifo_stream_rd.sv
// Read-side adapter for a FIFO with a 1-cycle registered read: turns read strobes into a
// valid/ready stream with a two-word (main + skid) buffer and a per-packet o_tlast tag.
module fifo_stream_rd #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  // Stream handshake: a beat transfers on a rising edge where o_tvalid and i_tready
  // are both high; while o_tvalid is high and i_tready low, o_tdata/o_tlast hold.

  logic [1:0]            r_occ;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic                  w_pop;
  logic [1:0]            w_occ_next;

  assign o_tvalid   = (r_occ != 2'd0);
  assign o_tdata    = r_main;
  assign o_tlast    = o_tvalid & (r_beat_cnt == LAST_BEAT);
  assign w_pop      = o_tvalid & i_tready;

  // r_occ + r_rd_pend never exceeds 2, so the 2-bit sum cannot wrap.
  assign w_occ_next = r_occ + 2'(r_rd_pend) - 2'(w_pop);
  assign o_fifo_rd  = !i_rst & i_en & !i_fifo_empty & (w_occ_next < 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ      <= 2'd0;
      r_rd_pend  <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_occ     <= w_occ_next;
      r_rd_pend <= o_fifo_rd;

      if (w_pop) begin
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
      end

      // Skid always holds the younger word, so it feeds main before any new landing.
      if (w_pop && (r_occ == 2'd2)) begin
        r_main <= r_skid;
        if (r_rd_pend) begin
          r_skid <= i_fifo_data;
        end
      end else if (r_rd_pend) begin
        if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) begin
          r_main <= i_fifo_data;
        end else begin
          r_skid <= i_fifo_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: a queue-based FIFO model feeds the DUT, and a negedge monitor
// scores the stream against an expected-word queue and a packet beat counter.
module tb_fifo_stream_rd;

  localparam int DW      = 8;
  localparam int PKT_LEN = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b1;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_tvalid;
  logic          i_tready = 1'b0;
  logic [DW-1:0] o_tdata;
  logic          o_tlast;

  always #5 clk = ~clk;

  fifo_stream_rd #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd   (o_fifo_rd),
    .i_fifo_data (i_fifo_data),
    .o_tvalid    (o_tvalid),
    .i_tready    (i_tready),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            rd_count = 0;
  int            pop_count = 0;
  int            exp_beat = 0;
  logic          s_rd = 1'b0;
  logic          prev_rd = 1'b0;
  int            m_held;
  int            m_pop;
  logic          m_exp_rd;
  logic [DW-1:0] next_val = 8'h10;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_val);
      next_val = next_val + 8'd1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_en = 1'b1;
    i_tready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  // FIFO model: a read seen at an edge presents its word 1 ns later; empty follows the queue.
  always @(posedge clk) begin
    #1;
    if (s_rd) begin
      if (fifo_q.size() > 0) begin
        i_fifo_data = fifo_q.pop_front();
        exp_q.push_back(i_fifo_data);
      end else begin
        i_fifo_data = '1;
      end
    end
    #1;
    i_fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: exp_q holds landed words followed by at most one in-flight word.
  always @(negedge clk) begin
    m_held = exp_q.size() - (prev_rd ? 1 : 0);
    chk("tvalid", o_tvalid, m_held > 0);
    chk("tlast", o_tlast, (m_held > 0) && (exp_beat == PKT_LEN - 1));
    if (m_held > 0) begin
      chk("tdata", o_tdata, exp_q[0]);
    end
    m_pop    = ((m_held > 0) && i_tready && !i_rst) ? 1 : 0;
    m_exp_rd = !i_rst && i_en && !i_fifo_empty && ((exp_q.size() - m_pop) < 2);
    chk("fifo_rd", o_fifo_rd, m_exp_rd);
    chk("occupancy_le2", exp_q.size() <= 2, 1);
    if (m_pop == 1) begin
      void'(exp_q.pop_front());
      exp_beat  = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
      pop_count++;
    end
    if (o_fifo_rd) rd_count++;
    s_rd = o_fifo_rd;
    if (i_rst) begin
      exp_q.delete();
      exp_beat = 0;
      prev_rd  = 1'b0;
    end else begin
      prev_rd = o_fifo_rd;
    end
  end

  initial begin
    int base;
    int n;

    // Reset held with a non-empty FIFO and reads enabled.
    fifo_q.push_back(8'hA0);
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    repeat (3) begin
      @(negedge clk);
      chk("rst_fifo_rd", o_fifo_rd, 0);
      chk("rst_tvalid", o_tvalid, 0);
      chk("rst_tdata", o_tdata, 0);
      chk("rst_tlast", o_tlast, 0);
    end
    step();
    i_rst = 1'b0;
    i_en  = 1'b0;
    fifo_q.delete();
    step();

    // Preloaded 0x01..0x08 streamed back-to-back.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
    step();
    i_en = 1'b1;
    i_tready = 1'b1;
    @(negedge clk);
    chk("lat_rd_same_cycle", o_fifo_rd, 1);
    step();
    @(negedge clk);
    chk("lat_valid_not_yet", o_tvalid, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", o_tvalid, 1);
      chk("stream_data", o_tdata, i + 1);
      chk("stream_last", o_tlast, (i % 4) == 3);
      step();
    end
    drain();

    // Backpressure mid-stream.
    push_words(12);
    repeat (3) step();
    i_tready = 1'b0;
    base = rd_count;
    repeat (5) step();
    chk("stall_reads_le2", (rd_count - base) <= 2, 1);
    drain();

    // Alternating ready over 16 words.
    push_words(16);
    base = pop_count;
    n = 0;
    while (pop_count < base + 16 && n < 200) begin
      i_tready = ~i_tready;
      step();
      n++;
    end
    chk("alt_ready_timeout", n < 200, 1);
    drain();

    // Enable dropped for 4 cycles.
    push_words(16);
    repeat (3) step();
    i_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("en_low_no_rd", o_fifo_rd, 0);
      step();
    end
    drain();

    // Reset one cycle after a read taken with two words held.
    push_words(10);
    i_tready = 1'b0;
    repeat (4) step();
    i_tready = 1'b1;
    step();
    i_rst = 1'b1;
    i_tready = 1'b0;
    step();
    i_rst = 1'b0;
    i_tready = 1'b1;
    @(negedge clk);
    chk("post_rst_tvalid", o_tvalid, 0);
    drain();

    // Randomized traffic with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) push_words($urandom_range(1, 3));
      i_tready = 1'($urandom_range(0, 1));
      i_en     = ($urandom_range(0, 3) != 0);
      i_rst    = ($urandom_range(0, 99) == 0);
      step();
    end
    i_rst = 1'b0;
    drain();
    chk("final_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
